// File: rtl/shift_engine.sv
// shift_engine: multi-cycle shift/rotate unit, one bit per clock.
//
// An operand, shift amount and mode are captured on an accepted start; the
// unit then applies one single-bit step per clock and raises done for one
// cycle when the result is final.
//
// Build option:
//   SHIFT_ROTATE_EN - when defined, mode 2'b11 is rotate-right. When not
//                     defined, the rotate logic is absent and mode 2'b11
//                     behaves exactly as logical shift right.
//
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst   - synchronous active-high reset
//   start - request, sampled only while busy is low
//   a     - operand, captured with start
//   amt   - shift count, captured with start (may exceed WIDTH-1)
//   mode  - 00 SLL, 01 SRL, 10 SRA, 11 ROR (or SRL, see above)
//   y     - result register, held until the next accepted start
//   co    - last bit shifted/rotated out, 0 when amt is 0
//   zero  - y == 0, updated with every write of y
//   busy  - high while shifting
//   done  - one-cycle pulse when y/co/zero are final
module shift_engine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] y,
    output logic             co,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             co_q, co_d;
    logic             zero_q, zero_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [1:0]       mode_q, mode_d;
    logic             y_we;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        co_d    = co_q;
        count_d = count_q;
        mode_d  = mode_q;
        y_we    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    y_d     = a;
                    count_d = amt;
                    mode_d  = mode;
                    co_d    = 1'b0;
                    y_we    = 1'b1;
                    // A zero amount skips SHIFT and finishes on the next cycle.
                    state_d = (amt != '0) ? ST_SHIFT : ST_DONE;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                y_we    = 1'b1;
                count_d = count_q - AMT_W'(1);
                case (mode_q)
                    MODE_SLL: begin
                        co_d = y_q[WIDTH-1];
                        y_d  = {y_q[WIDTH-2:0], 1'b0};
                    end
                    MODE_SRA: begin
                        co_d = y_q[0];
                        y_d  = {y_q[WIDTH-1], y_q[WIDTH-1:1]};
                    end
`ifdef SHIFT_ROTATE_EN
                    MODE_ROR: begin
                        co_d = y_q[0];
                        y_d  = {y_q[0], y_q[WIDTH-1:1]};
                    end
`endif
                    // SRL, and mode 11 when rotate is not built in.
                    default: begin
                        co_d = y_q[0];
                        y_d  = {1'b0, y_q[WIDTH-1:1]};
                    end
                endcase
                if (count_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        zero_d = y_we ? (y_d == '0) : zero_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            co_q    <= 1'b0;
            zero_q  <= 1'b0;
            count_q <= '0;
            mode_q  <= MODE_SLL;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            co_q    <= co_d;
            zero_q  <= zero_d;
            count_q <= count_d;
            mode_q  <= mode_d;
        end
    end

    // MODE_SRL is the default branch of the step decode.
    logic unused_mode_srl;
    assign unused_mode_srl = ^MODE_SRL ^ ^MODE_ROR;

    assign y    = y_q;
    assign co   = co_q;
    assign zero = zero_q;
    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine (WIDTH=8, AMT_W=4) with a result
// scoreboard: expected results are pushed on launch and popped on done.
module tb_shift_engine;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [3:0] amt;
    logic [1:0] mode;
    logic [7:0] y;
    logic       co;
    logic       zero;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] y;
        logic       co;
        logic       zero;
        int         lat;
    } res_t;

    res_t sb[$];

    shift_engine #(
        .WIDTH(8),
        .AMT_W(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .amt  (amt),
        .mode (mode),
        .y    (y),
        .co   (co),
        .zero (zero),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: apply amt single-bit steps to the operand.
    function automatic res_t model(input logic [7:0] av, input logic [3:0] amtv,
                                   input logic [1:0] mv);
        res_t r;
        logic [7:0] v;
        logic c;
        v = av;
        c = 1'b0;
        for (int i = 0; i < int'(amtv); i++) begin
            case (mv)
                2'b00: begin c = v[7]; v = v << 1; end
                2'b10: begin c = v[0]; v = {v[7], v[7:1]}; end
`ifdef SHIFT_ROTATE_EN
                2'b11: begin c = v[0]; v = {v[0], v[7:1]}; end
`endif
                default: begin c = v[0]; v = v >> 1; end
            endcase
        end
        r.y = v;
        r.co = c;
        r.zero = (v == 8'h00);
        r.lat = int'(amtv);  // done visible after edge E0+amt
        return r;
    endfunction

    // Drive one start; returns one #1 after the sampling edge E0.
    task automatic launch(input logic [7:0] av, input logic [3:0] amtv, input logic [1:0] mv);
        sb.push_back(model(av, amtv, mv));
        @(negedge clk);
        a = av; amt = amtv; mode = mv; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait (bounded) for done; report observed result, edges since E0,
    // busy-high samples and the expected entry from the scoreboard.
    task automatic collect(input int lat0, input int busy0, output res_t obs,
                           output int busyc, output logic to, output res_t exp_r);
        int lat;
        lat = lat0;
        busyc = busy0;
        while (!done && lat < 40) begin
            if (busy) busyc++;
            @(posedge clk);
            #1;
            lat++;
        end
        to = !done;
        obs.y = y;
        obs.co = co;
        obs.zero = zero;
        obs.lat = lat;
        if (sb.size() > 0) exp_r = sb.pop_front();
        else exp_r = '{y: 8'hxx, co: 1'bx, zero: 1'bx, lat: -1};
    endtask

    task automatic test_reset();
        res_t obs, e;
        int bc;
        logic to;
        int seen_done;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({y, co, zero, busy, done} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_init: got y=%h co=%b zero=%b busy=%b done=%b, want all 0",
                     y, co, zero, busy, done);
        end
        @(negedge clk) rst = 1'b0;
        // Abort an amt=10 operation mid-SHIFT.
        launch(8'hA5, 4'd10, 2'b00);
        void'(sb.pop_back());
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({y, co, zero, busy, done} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_mid_shift: got y=%h co=%b zero=%b busy=%b done=%b, want all 0",
                     y, co, zero, busy, done);
        end
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        seen_done = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d done/busy cycles after abort, want 0", seen_done);
        end
        launch(8'h0F, 4'd1, 2'b00);
        collect(0, 0, obs, bc, to, e);
        n_checks++;
        if (to || obs.y !== 8'h1E || obs.co !== 1'b0 || obs.lat != 1) begin
            n_fail++;
            $display("FAIL reset_restart: got y=%h co=%b lat=%0d to=%b, want y=1e co=0 lat=1",
                     obs.y, obs.co, obs.lat, to);
        end
    endtask

    task automatic test_sll();
        res_t obs, e;
        int bc;
        logic to;
        launch(8'b1001_0110, 4'd3, 2'b00);
        collect(0, 0, obs, bc, to, e);
        n_checks++;
        if (to || obs.y !== 8'b1011_0000 || obs.co !== 1'b0 || obs.zero !== 1'b0) begin
            n_fail++;
            $display("FAIL sll3: got y=%h co=%b zero=%b to=%b, want y=b0 co=0 zero=0",
                     obs.y, obs.co, obs.zero, to);
        end
        n_checks++;
        if (obs.lat != e.lat || bc != 3) begin
            n_fail++;
            $display("FAIL sll3_timing: got lat=%0d busy=%0d, want lat=%0d busy=3",
                     obs.lat, bc, e.lat);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || y !== 8'b1011_0000) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%b y=%h one cycle later, want done=0 y=b0",
                     done, y);
        end
    endtask

    task automatic test_sra();
        res_t obs, e;
        int bc;
        logic to;
        launch(8'b1000_0001, 4'd2, 2'b10);
        collect(0, 0, obs, bc, to, e);
        n_checks++;
        if (to || obs.y !== 8'b1110_0000 || obs.co !== 1'b0 || obs.lat != e.lat) begin
            n_fail++;
            $display("FAIL sra2: got y=%h co=%b lat=%0d, want y=e0 co=0 lat=%0d",
                     obs.y, obs.co, obs.lat, e.lat);
        end
        launch(8'b1000_0000, 4'd12, 2'b10);
        collect(0, 0, obs, bc, to, e);
        n_checks++;
        if (to || obs.y !== 8'hFF || obs.co !== 1'b1 || obs.lat != 12 || bc != 12) begin
            n_fail++;
            $display("FAIL sra12: got y=%h co=%b lat=%0d busy=%0d, want y=ff co=1 lat=12 busy=12",
                     obs.y, obs.co, obs.lat, bc);
        end
    endtask

    task automatic test_mode11();
        res_t obs, e;
        int bc;
        logic to;
        logic [7:0] want;
`ifdef SHIFT_ROTATE_EN
        want = 8'b1100_0000;
`else
        want = 8'b0100_0000;
`endif
        launch(8'b1000_0001, 4'd1, 2'b11);
        collect(0, 0, obs, bc, to, e);
        n_checks++;
        if (to || obs.y !== want || obs.co !== 1'b1 || obs.y !== e.y) begin
            n_fail++;
            $display("FAIL mode11: got y=%h co=%b, want y=%h co=1", obs.y, obs.co, want);
        end
        // Rotate by more than WIDTH wraps (mod 8); SRL clears.
        launch(8'b0110_1001, 4'd11, 2'b11);
        collect(0, 0, obs, bc, to, e);
        n_checks++;
        if (to || obs.y !== e.y || obs.co !== e.co || obs.zero !== e.zero) begin
            n_fail++;
            $display("FAIL mode11_wrap: got y=%h co=%b zero=%b, want y=%h co=%b zero=%b",
                     obs.y, obs.co, obs.zero, e.y, e.co, e.zero);
        end
    endtask

    task automatic test_zero();
        res_t obs, e;
        int bc;
        logic to;
        launch(8'h00, 4'd0, 2'b01);
        collect(0, 0, obs, bc, to, e);
        n_checks++;
        if (to || obs.y !== 8'h00 || obs.co !== 1'b0 || obs.zero !== 1'b1 || obs.lat != 0
            || bc != 0) begin
            n_fail++;
            $display("FAIL amt0: got y=%h co=%b zero=%b lat=%0d busy=%0d, want 00 0 1 0 0",
                     obs.y, obs.co, obs.zero, obs.lat, bc);
        end
        launch(8'hFF, 4'd8, 2'b00);
        collect(0, 0, obs, bc, to, e);
        n_checks++;
        if (to || obs.y !== 8'h00 || obs.co !== 1'b1 || obs.zero !== 1'b1 || obs.lat != 8) begin
            n_fail++;
            $display("FAIL sll8: got y=%h co=%b zero=%b lat=%0d, want 00 1 1 8",
                     obs.y, obs.co, obs.zero, obs.lat);
        end
    endtask

    task automatic test_back_to_back();
        res_t obs, e;
        int bc;
        logic to;
        launch(8'b1100_1010, 4'd5, 2'b01);
        @(posedge clk);
        #1;
        // Start sampled at E0+2 while busy: must be ignored.
        @(negedge clk);
        a = 8'h3C; amt = 4'd1; mode = 2'b00; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        collect(2, 2, obs, bc, to, e);
        n_checks++;
        if (to || obs.y !== 8'b0000_0110 || obs.co !== 1'b0 || obs.lat != 5 || bc != 5) begin
            n_fail++;
            $display("FAIL busy_ignore: got y=%h co=%b lat=%0d busy=%0d, want 06 0 5 5",
                     obs.y, obs.co, obs.lat, bc);
        end
        // Next start lands in the DONE cycle.
        launch(8'b0101_0011, 4'd4, 2'b10);
        n_checks++;
        if (busy !== 1'b1 || y !== 8'b0101_0011) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b y=%h after E0, want busy=1 y=53", busy, y);
        end
        collect(0, 0, obs, bc, to, e);
        n_checks++;
        if (to || obs.y !== e.y || obs.co !== e.co || obs.lat != 4 || bc != 4) begin
            n_fail++;
            $display("FAIL b2b_second: got y=%h co=%b lat=%0d busy=%0d, want %h %b 4 4",
                     obs.y, obs.co, obs.lat, bc, e.y, e.co);
        end
    endtask

    task automatic test_random();
        res_t obs, e;
        int bc;
        logic to;
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            launch(8'($urandom), 4'($urandom), 2'($urandom));
            collect(0, 0, obs, bc, to, e);
            n_checks++;
            if (to || obs.y !== e.y || obs.co !== e.co || obs.zero !== e.zero
                || obs.lat != e.lat) begin
                n_fail++;
                $display("FAIL random_%0d: got y=%h co=%b zero=%b lat=%0d, want %h %b %b %0d",
                         i, obs.y, obs.co, obs.zero, obs.lat, e.y, e.co, e.zero, e.lat);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        amt = '0;
        mode = '0;
        test_reset();
        test_sll();
        test_sra();
        test_mode11();
        test_zero();
        test_back_to_back();
        test_random();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d leftover entries, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
